// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, branch/jump redirects, MDU sequencing.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mdu_start,
  input  logic        branch_taken,
  input  logic        jump,
  output logic        stall_if,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        pc_redirect,
  output logic        mdu_busy,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [0:0] {RUN, MDU_WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   mdu_cnt_q, mdu_cnt_d;
  logic               redirect;
  logic               load_use;

  assign redirect = branch_taken | jump;
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d     = state_q;
    mdu_cnt_d   = mdu_cnt_q;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    pc_redirect = 1'b0;
    mdu_busy    = 1'b0;
    unique case (state_q)
      RUN: begin
        // Redirect squashes everything younger, so it outranks both MDU start and load-use.
        if (redirect) begin
          pc_redirect = 1'b1;
          flush_id    = 1'b1;
          flush_ex    = 1'b1;
        end else if (ex_mdu_start) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          mdu_busy  = 1'b1;
          mdu_cnt_d = CNT_W'(MDU_LATENCY - 1);
          state_d   = MDU_WAIT;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end
      MDU_WAIT: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_ex  = 1'b1;
        mdu_busy  = 1'b1;
        mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
        if (mdu_cnt_q == CNT_W'(1)) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Flush wins over stall in the same pipeline register.
    stall_id = stall_id & ~flush_id;
    if (rst) begin
      state_d     = RUN;
      mdu_cnt_d   = '0;
      stall_if    = 1'b0;
      stall_id    = 1'b0;
      stall_ex    = 1'b0;
      flush_id    = 1'b0;
      flush_ex    = 1'b0;
      pc_redirect = 1'b0;
      mdu_busy    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_if};
    perf_flush_d = perf_flush_q + {31'd0, pc_redirect};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule
